// File: rtl/div_operand_sequencer.sv
// Division-path front end: assembles big-endian 16-bit operands P and Q from a
// byte stream, holds them for the divider to settle, then registers the result.
module div_operand_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] op_p,
  output logic [15:0] op_q,
  input  logic [31:0] div_quotient,
  input  logic [1:0]  div_by_zero,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    LOAD,
    SETTLE,
    HOLD
  } state_e;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [3:0]  scnt_q, scnt_d;
  logic [15:0] op_p_q, op_p_d;
  logic [15:0] op_q_q, op_q_d;
  logic [31:0] res_data_q, res_data_d;
  logic        res_err_q, res_err_d;
  logic        res_valid_q, res_valid_d;

  // Upper error-code bit carries no meaning for this block.
  logic unused_dbz_hi;
  assign unused_dbz_hi = div_by_zero[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      bcnt_q      <= '0;
      scnt_q      <= '0;
      op_p_q      <= '0;
      op_q_q      <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      scnt_q      <= scnt_d;
      op_p_q      <= op_p_d;
      op_q_q      <= op_q_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    scnt_d      = scnt_q;
    op_p_d      = op_p_q;
    op_q_d      = op_q_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = res_valid_q;

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          unique case (bcnt_q)
            2'd0: op_p_d[15:8] = in_byte;
            2'd1: op_p_d[7:0]  = in_byte;
            2'd2: op_q_d[15:8] = in_byte;
            2'd3: op_q_d[7:0]  = in_byte;
            default: ;
          endcase
          // Counter parks at 3; it only returns to 0 on leaving HOLD or clear.
          if (bcnt_q == 2'd3) begin
            scnt_d  = SETTLE_INIT;
            state_d = SETTLE;
          end else begin
            bcnt_d = bcnt_q + 2'd1;
          end
        end
      end
      SETTLE: begin
        if (scnt_q != 4'd0) begin
          scnt_d = scnt_q - 4'd1;
        end else begin
          res_err_d   = div_by_zero[0];
          res_data_d  = div_by_zero[0] ? '0 : div_quotient;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          bcnt_d      = '0;
          state_d     = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    // Flush overrides everything above but keeps operands and last result data.
    if (clear) begin
      state_d     = LOAD;
      bcnt_d      = '0;
      scnt_d      = '0;
      res_valid_d = 1'b0;
      op_p_d      = op_p_q;
      op_q_d      = op_q_q;
      res_data_d  = res_data_q;
      res_err_d   = res_err_q;
    end
  end

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != LOAD);
  assign op_p      = op_p_q;
  assign op_q      = op_q_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;
  assign res_valid = res_valid_q;

endmodule

// File: doc/div_operand_sequencer.md
# div_operand_sequencer

Front-end sequencer for the calculator's division path. It accepts a byte stream from the host interface and assembles two 16-bit operands, P then Q. It holds them stable on the combinational divider's inputs for a programmable settle time, then captures the 32-bit quotient and divide-by-zero flag into a result register. That register is presented downstream with a valid/ready handshake.

## Interface
- SETTLE_CYCLES, default 1: cycles operands are held stable before the divider output is sampled; legal range 1..15.
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- clear  in  1  synchronous flush; discards partial operands and any pending result
- in_byte  in  8  operand byte from host
- in_valid  in  1  in_byte is valid
- in_ready  out  1  sequencer accepts a byte this cycle
- op_p  out  16  dividend to divider
- op_q  out  16  divisor to divider
- div_quotient  in  32  quotient from divider
- div_by_zero  in  2  divider error code; bit 0 = divide by zero, bit 1 ignored
- res_data  out  32  captured quotient
- res_err  out  1  captured divide-by-zero flag
- res_valid  out  1  result available
- res_ready  in  1  downstream consumes result
- busy  out  1  high whenever state is not LOAD

## Operation
- States: LOAD, SETTLE, HOLD.
- **LOAD**
  - in_ready=1.
  - A byte is accepted on an edge where in_valid && in_ready.
  - A 2-bit byte counter selects the destination, big-endian:
    - byte 0 → op_p[15:8]
    - byte 1 → op_p[7:0]
    - byte 2 → op_q[15:8]
    - byte 3 → op_q[7:0]
  - Accepting byte 3 loads settle counter = SETTLE_CYCLES-1 and moves to SETTLE.
- **SETTLE**
  - in_ready=0; op_p/op_q are frozen.
  - If the counter is nonzero, it decrements each edge.
  - When the counter is 0, the next edge captures the divider output and moves to HOLD:
    - res_err ← div_by_zero[0]
    - res_data ← div_by_zero[0] ? 32'h0 : div_quotient
    - res_valid ← 1
- **HOLD**
  - in_ready=0.
  - res_valid, res_data and res_err stay constant until res_ready=1.
  - On that edge: res_valid←0, byte counter←0, state←LOAD.
  - op_p/op_q keep their old values until overwritten byte by byte.
- **Priority:** rst > clear > normal operation.
- **clear** (any state):
  - state←LOAD, byte counter←0, settle counter←0, res_valid←0.
  - op_p, op_q, res_data and res_err are retained.
- **Reset values:**
  - state LOAD, counters 0.
  - op_p=0, op_q=0, res_data=0, res_err=0, res_valid=0.
  - in_ready=1 and busy=0 once rst deasserts.
- in_valid while in_ready=0 is ignored; the byte is not accepted, and holding it is the host's responsibility.
- res_ready outside HOLD has no effect.
- Arithmetic: no arithmetic is performed locally. The quotient is passed through unmodified except for forcing it to zero on error.

## Timing
- in_ready, busy: decoded combinationally from state only, with no combinational path from in_valid or res_ready.
- All other outputs are registered.
- Latency: byte 3 accepted at edge E0 → res_valid high after edge E0+SETTLE_CYCLES. For SETTLE_CYCLES=1, it rises one edge after the final byte is accepted.
- Throughput with res_ready tied high: one result per 4+SETTLE_CYCLES+1 cycles; HOLD lasts exactly one cycle.
- **Boundary cases:**
  - Mid-operand pauses (in_valid low) stall the counter indefinitely without corruption.
  - Byte counter wrap 3→0 happens only via the HOLD→LOAD transition or clear.
  - clear and res_ready in the same HOLD cycle: clear wins, result discarded, res_valid←0.
  - rst asserted in any state: all registers go to reset values immediately, independent of clk.
  - The first edge after deassertion behaves as in LOAD.

## Test plan
- Reset mid-SETTLE, then the stream 00 64 00 07 with SETTLE_CYCLES=1:
  - all outputs are zero during reset;
  - after the final byte, op_p=0x0064 and op_q=0x0007;
  - one edge later, res_valid=1, res_data=0x0000000E, res_err=0.
- Stream FF FF 00 01 → res_data=0x0000FFFF, res_err=0.
- Stream 00 05 00 09 → res_data=0x00000000, res_err=0, indicating P<Q.
- Stream 12 34 00 00, with divider div_by_zero=2'b01 → res_err=1, res_data=0x00000000.
- Backpressure:
  - hold res_ready=0 for 5 cycles after res_valid while asserting in_valid with new bytes;
  - res_valid, res_data and res_err stay constant and in_ready=0;
  - on res_ready=1, res_valid drops next edge, in_ready=1, and the next byte lands in op_p[15:8].
- Flush and settle timing:
  - send 2 bytes, assert clear for 1 cycle, then send 00 0A 00 02 → res_data=0x00000005, so partial bytes were discarded;
  - with SETTLE_CYCLES=3, res_valid rises exactly 3 edges after the final byte is accepted.
